// File: rtl/video_bus_arbiter.sv
// Three-way arbiter (display channels A/B, CPU) sharing one 16-bit memory read port.
// Optional bus watchdog is compiled in when BUS_TIMEOUT_EN is defined.
module video_bus_arbiter #(
    parameter int unsigned ADDR_W         = 22,
    parameter int unsigned CPU_MAX_WAIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_as,
    output logic              a_ack,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_as,
    output logic              b_ack,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_as,
    output logic              cpu_ack,
    output logic [15:0]       dout,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_as,
    input  logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [1:0]  GNT_NONE = 2'd0;
    localparam logic [1:0]  GNT_A    = 2'd1;
    localparam logic [1:0]  GNT_B    = 2'd2;
    localparam logic [1:0]  GNT_CPU  = 2'd3;
    localparam int unsigned WAIT_W   = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_e            state_q;
    logic [1:0]        grant_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_as_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              cpu_ack_q;
    logic [15:0]       dout_q;
    logic [WAIT_W-1:0] wait_q;
    logic              rr_b_q;

    logic              cpu_starved_c;
    logic [1:0]        win_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [2:0]        ack_vec_c;
    logic              cpl_c;
    logic [15:0]       cpl_data_c;

    assign cpu_starved_c = (wait_q >= WAIT_W'(CPU_MAX_WAIT));

    // Winner selection: starved CPU, then A/B round-robin, then CPU.
    always_comb begin
        win_c = GNT_NONE;
        if (cpu_as && cpu_starved_c) begin
            win_c = GNT_CPU;
        end else if (a_as && b_as) begin
            win_c = rr_b_q ? GNT_B : GNT_A;
        end else if (a_as) begin
            win_c = GNT_A;
        end else if (b_as) begin
            win_c = GNT_B;
        end else if (cpu_as) begin
            win_c = GNT_CPU;
        end
    end

    always_comb begin
        win_addr_c = cpu_address;
        case (win_c)
            GNT_A:   win_addr_c = a_address;
            GNT_B:   win_addr_c = b_address;
            default: win_addr_c = cpu_address;
        endcase
    end

    always_comb begin
        ack_vec_c = 3'b000;
        case (grant_q)
            GNT_A:   ack_vec_c = 3'b100;
            GNT_B:   ack_vec_c = 3'b010;
            GNT_CPU: ack_vec_c = 3'b001;
            default: ack_vec_c = 3'b000;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_err_q;
    logic             tmo_hit_c;

    // An access completes on mem_ack, or is aborted with all-ones data once the watchdog expires.
    always_comb begin
        cpl_c      = 1'b0;
        cpl_data_c = mem_din;
        tmo_hit_c  = 1'b0;
        if (state_q == ST_BUSY) begin
            if (mem_ack) begin
                cpl_c = 1'b1;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                cpl_c      = 1'b1;
                tmo_hit_c  = 1'b1;
                cpl_data_c = 16'hFFFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == ST_BUSY && !cpl_c) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end else begin
                tmo_q <= '0;
            end
            if (tmo_hit_c) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    always_comb begin
        cpl_c      = (state_q == ST_BUSY) && mem_ack;
        cpl_data_c = mem_din;
    end

    assign timeout_err = 1'b0;
`endif

    // Access sequencer: IDLE -> BUSY -> RELEASE -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= GNT_NONE;
            mem_address_q <= '0;
            mem_as_q      <= 1'b0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dout_q        <= '0;
            wait_q        <= '0;
            rr_b_q        <= 1'b0;
        end else begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            cpu_ack_q <= 1'b0;
            if (!cpu_as) begin
                wait_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (win_c != GNT_NONE) begin
                        grant_q       <= win_c;
                        mem_address_q <= win_addr_c;
                        mem_as_q      <= 1'b1;
                        state_q       <= ST_BUSY;
                        if (win_c == GNT_CPU) begin
                            wait_q <= '0;
                        end else begin
                            rr_b_q <= (win_c == GNT_A);
                            if (cpu_as && !cpu_starved_c) begin
                                wait_q <= wait_q + WAIT_W'(1);
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (cpl_c) begin
                        dout_q                           <= cpl_data_c;
                        {a_ack_q, b_ack_q, cpu_ack_q}    <= ack_vec_c;
                        mem_as_q                         <= 1'b0;
                        state_q                          <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    grant_q <= GNT_NONE;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign dout        = dout_q;
    assign mem_address = mem_address_q;
    assign mem_as      = mem_as_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Self-checking bench for video_bus_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level arbitration model.
module tb_video_bus_arbiter;

    localparam int unsigned ADDR_W         = 22;
    localparam int unsigned CPU_MAX_WAIT   = 4;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] a_address, b_address, cpu_address, mem_address;
    logic              a_as, b_as, cpu_as;
    logic              a_ack, b_ack, cpu_ack;
    logic [15:0]       dout, mem_din;
    logic              mem_as, mem_ack, timeout_err;
    logic [1:0]        grant;

    int n_cmp;
    int n_err;

    video_bus_arbiter #(
        .ADDR_W         (ADDR_W),
        .CPU_MAX_WAIT   (CPU_MAX_WAIT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_address   (a_address),
        .a_as        (a_as),
        .a_ack       (a_ack),
        .b_address   (b_address),
        .b_as        (b_as),
        .b_ack       (b_ack),
        .cpu_address (cpu_address),
        .cpu_as      (cpu_as),
        .cpu_ack     (cpu_ack),
        .dout        (dout),
        .mem_address (mem_address),
        .mem_as      (mem_as),
        .mem_din     (mem_din),
        .mem_ack     (mem_ack),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [2:0] ack_of(input logic [1:0] g);
        case (g)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        a_as = 1'b0; b_as = 1'b0; cpu_as = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Plays the memory side of one access; records observations only.
    task automatic serve(input int lat, input logic [15:0] data, input bit scramble, input bit drop,
                         output bit got, output int wait_cyc, output logic [1:0] g_grant,
                         output logic [ADDR_W-1:0] g_addr, output logic [ADDR_W-1:0] end_addr,
                         output logic [2:0] busy_acks, output logic [2:0] rel_acks,
                         output logic [15:0] rel_dout, output logic rel_as,
                         output logic [1:0] idle_grant, output logic [2:0] idle_acks);
        logic [ADDR_W-1:0] sa, sb, sc;
        got = 1'b0; wait_cyc = 0; g_grant = '0; g_addr = '0; end_addr = '0;
        busy_acks = '0; rel_acks = '0; rel_dout = '0; rel_as = 1'b0;
        idle_grant = '0; idle_acks = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            wait_cyc = i + 1;
            if (mem_as === 1'b1) got = 1'b1;
        end
        if (!got) return;
        g_grant = grant;
        g_addr  = mem_address;
        sa = a_address; sb = b_address; sc = cpu_address;
        if (drop) begin
            a_as = 1'b0; b_as = 1'b0; cpu_as = 1'b0;
        end
        for (int i = 0; i < lat; i++) begin
            busy_acks |= {a_ack, b_ack, cpu_ack};
            if (scramble) begin
                a_address = ADDR_W'($urandom);
                b_address = ADDR_W'($urandom);
                cpu_address = ADDR_W'($urandom);
            end
            @(negedge clk);
        end
        busy_acks |= {a_ack, b_ack, cpu_ack};
        end_addr = mem_address;
        mem_ack = 1'b1;
        mem_din = data;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_din = 16'($urandom);
        rel_acks = {a_ack, b_ack, cpu_ack};
        rel_dout = dout;
        rel_as   = mem_as;
        a_address = sa; b_address = sb; cpu_address = sc;
        @(negedge clk);
        idle_grant = grant;
        idle_acks  = {a_ack, b_ack, cpu_ack};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_as = 1'b1; b_as = 1'b1; cpu_as = 1'b1; mem_ack = 1'b1;
        a_address = 22'h12345; b_address = 22'h23456; cpu_address = 22'h34567;
        mem_din = 16'hA5A5;
        repeat (3) @(negedge clk);
        n_cmp++; if (grant !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant); end
        n_cmp++; if (mem_as !== 1'b0) begin n_err++; $display("FAIL reset_mem_as: got %b want 0", mem_as); end
        n_cmp++; if (mem_address !== '0) begin n_err++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
        n_cmp++; if ({a_ack, b_ack, cpu_ack} !== 3'b000) begin n_err++; $display("FAIL reset_acks: got %b want 000", {a_ack, b_ack, cpu_ack}); end
        n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        do_reset();
    endtask

    task automatic test_single_a();
        bit got; int wc; logic [1:0] gg, ig; logic [ADDR_W-1:0] ga, ea;
        logic [2:0] ba, ra, ia; logic [15:0] rd; logic ras;
        do_reset();
        a_address = 22'h076370;
        b_address = 22'h000111;
        cpu_address = 22'h000222;
        a_as = 1'b1;
        serve(3, 16'h1234, 1'b1, 1'b0, got, wc, gg, ga, ea, ba, ra, rd, ras, ig, ia);
        a_as = 1'b0;
        n_cmp++; if (!got) begin n_err++; $display("FAIL single_mem_as: got none want mem_as within 8 cycles"); end
        n_cmp++; if (wc !== 1) begin n_err++; $display("FAIL single_latency: got %0d want 1", wc); end
        n_cmp++; if (gg !== 2'd1) begin n_err++; $display("FAIL single_grant: got %0d want 1", gg); end
        n_cmp++; if (ga !== 22'h076370) begin n_err++; $display("FAIL single_addr: got %h want 076370", ga); end
        n_cmp++; if (ea !== 22'h076370) begin n_err++; $display("FAIL single_addr_hold: got %h want 076370", ea); end
        n_cmp++; if (ba !== 3'b000) begin n_err++; $display("FAIL single_early_ack: got %b want 000", ba); end
        n_cmp++; if (ra !== 3'b100) begin n_err++; $display("FAIL single_ack: got %b want 100", ra); end
        n_cmp++; if (rd !== 16'h1234) begin n_err++; $display("FAIL single_dout: got %h want 1234", rd); end
        n_cmp++; if (ras !== 1'b0) begin n_err++; $display("FAIL single_release_as: got %b want 0", ras); end
        n_cmp++; if (ig !== 2'd0) begin n_err++; $display("FAIL single_grant_clear: got %0d want 0", ig); end
        n_cmp++; if (ia !== 3'b000) begin n_err++; $display("FAIL single_ack_pulse: got %b want 000", ia); end
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_as !== 1'b0) begin n_err++; $display("FAIL single_no_rearb: got %b want 0", mem_as); end
    endtask

    task automatic test_alternate();
        bit got; int wc; logic [1:0] gg, ig, exp; logic [ADDR_W-1:0] ga, ea;
        logic [2:0] ba, ra, ia; logic [15:0] rd, d; logic ras;
        do_reset();
        a_address = 22'h000100; b_address = 22'h000200;
        a_as = 1'b1; b_as = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 0) ? 2'd1 : 2'd2;
            d = 16'($urandom);
            serve($urandom_range(0, 3), d, 1'b0, 1'b0, got, wc, gg, ga, ea, ba, ra, rd, ras, ig, ia);
            n_cmp++; if (gg !== exp) begin n_err++; $display("FAIL alt_grant[%0d]: got %0d want %0d", i, gg, exp); end
            n_cmp++; if (ga !== ((exp == 2'd1) ? 22'h000100 : 22'h000200)) begin n_err++; $display("FAIL alt_addr[%0d]: got %h", i, ga); end
            n_cmp++; if (ra !== ack_of(exp)) begin n_err++; $display("FAIL alt_ack[%0d]: got %b want %b", i, ra, ack_of(exp)); end
            n_cmp++; if (rd !== d) begin n_err++; $display("FAIL alt_dout[%0d]: got %h want %h", i, rd, d); end
        end
        a_as = 1'b0; b_as = 1'b0;
    endtask

    task automatic test_cpu_starvation();
        bit got; int wc; logic [1:0] gg, ig; logic [ADDR_W-1:0] ga, ea;
        logic [2:0] ba, ra, ia; logic [15:0] rd; logic ras;
        logic [1:0] seq [0:9];
        seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
        do_reset();
        a_address = 22'h0A0000; b_address = 22'h0B0000; cpu_address = 22'h0C0000;
        a_as = 1'b1; b_as = 1'b1; cpu_as = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serve(1, 16'(i), 1'b0, 1'b0, got, wc, gg, ga, ea, ba, ra, rd, ras, ig, ia);
            n_cmp++; if (gg !== seq[i]) begin n_err++; $display("FAIL starve_grant[%0d]: got %0d want %0d", i, gg, seq[i]); end
            n_cmp++; if (ra !== ack_of(seq[i])) begin n_err++; $display("FAIL starve_ack[%0d]: got %b want %b", i, ra, ack_of(seq[i])); end
        end
        a_as = 1'b0; b_as = 1'b0; cpu_as = 1'b0;
    endtask

    task automatic test_cpu_drop();
        bit got; int wc; logic [1:0] gg, ig; logic [ADDR_W-1:0] ga, ea;
        logic [2:0] ba, ra, ia; logic [15:0] rd; logic ras;
        logic [1:0] seq [0:7];
        logic       cpu_on [0:7];
        seq    = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3};
        cpu_on = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        a_as = 1'b1; b_as = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cpu_as = cpu_on[i];
            serve(2, 16'hC000 + 16'(i), 1'b0, 1'b0, got, wc, gg, ga, ea, ba, ra, rd, ras, ig, ia);
            n_cmp++; if (gg !== seq[i]) begin n_err++; $display("FAIL drop_grant[%0d]: got %0d want %0d", i, gg, seq[i]); end
        end
        a_as = 1'b0; b_as = 1'b0; cpu_as = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [2:0] acc;
        do_reset();
        a_address = 22'h055555; a_as = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_as !== 1'b1) begin n_err++; $display("FAIL rst_busy_start: got %b want 1", mem_as); end
        @(negedge clk);
        reset = 1'b1; a_as = 1'b0; mem_ack = 1'b1; mem_din = 16'hBEEF;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        n_cmp++; if (mem_as !== 1'b0) begin n_err++; $display("FAIL rst_busy_mem_as: got %b want 0", mem_as); end
        n_cmp++; if (grant !== 2'd0) begin n_err++; $display("FAIL rst_busy_grant: got %0d want 0", grant); end
        acc = {a_ack, b_ack, cpu_ack};
        @(negedge clk);
        mem_ack = 1'b1; mem_din = 16'hCAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc |= {a_ack, b_ack, cpu_ack};
            @(negedge clk);
        end
        n_cmp++; if (acc !== 3'b000) begin n_err++; $display("FAIL rst_busy_acks: got %b want 000", acc); end
        n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL rst_busy_dout: got %h want 0", dout); end
        n_cmp++; if (mem_as !== 1'b0) begin n_err++; $display("FAIL rst_busy_idle_ack: got %b want 0", mem_as); end
    endtask

    task automatic test_random();
        bit got; int wc; logic [1:0] gg, ig; logic [ADDR_W-1:0] ga, ea;
        logic [2:0] ba, ra, ia; logic [15:0] rd; logic ras;
        int mw; bit ptr_b; bit dr; logic [2:0] m; logic [1:0] exp;
        logic [ADDR_W-1:0] exp_addr; logic [15:0] d;
        do_reset();
        mw = 0; ptr_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            m = 3'($urandom_range(1, 7));
            a_as = m[2]; b_as = m[1]; cpu_as = m[0];
            a_address = ADDR_W'($urandom);
            b_address = ADDR_W'($urandom);
            cpu_address = ADDR_W'($urandom);
            d  = 16'($urandom);
            dr = ($urandom_range(0, 3) == 0);
            if (!m[0]) mw = 0;
            if (m[0] && mw >= int'(CPU_MAX_WAIT)) exp = 2'd3;
            else if (m[2] && m[1]) exp = ptr_b ? 2'd2 : 2'd1;
            else if (m[2]) exp = 2'd1;
            else if (m[1]) exp = 2'd2;
            else exp = 2'd3;
            if (exp == 2'd3) begin
                mw = 0;
            end else begin
                ptr_b = (exp == 2'd1);
                if (m[0] && mw < int'(CPU_MAX_WAIT)) mw++;
            end
            if (dr) mw = 0;
            exp_addr = (exp == 2'd1) ? a_address : (exp == 2'd2) ? b_address : cpu_address;
            serve($urandom_range(0, 4), d, 1'b1, dr, got, wc, gg, ga, ea, ba, ra, rd, ras, ig, ia);
            n_cmp++; if (!got) begin n_err++; $display("FAIL rnd_mem_as[%0d]: got none want mem_as", i); end
            n_cmp++; if (gg !== exp) begin n_err++; $display("FAIL rnd_grant[%0d]: got %0d want %0d (req %b)", i, gg, exp, m); end
            n_cmp++; if (ga !== exp_addr) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, ga, exp_addr); end
            n_cmp++; if (ea !== exp_addr) begin n_err++; $display("FAIL rnd_addr_hold[%0d]: got %h want %h", i, ea, exp_addr); end
            n_cmp++; if (ba !== 3'b000) begin n_err++; $display("FAIL rnd_early_ack[%0d]: got %b want 000", i, ba); end
            n_cmp++; if (ra !== ack_of(exp)) begin n_err++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, ra, ack_of(exp)); end
            n_cmp++; if (rd !== d) begin n_err++; $display("FAIL rnd_dout[%0d]: got %h want %h", i, rd, d); end
            n_cmp++; if (ig !== 2'd0 || ia !== 3'b000) begin n_err++; $display("FAIL rnd_release[%0d]: got grant %0d acks %b want 0/000", i, ig, ia); end
        end
        a_as = 1'b0; b_as = 1'b0; cpu_as = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n; bit seen; logic [2:0] acc;
        do_reset();
        cpu_address = 22'h02AB0C; cpu_as = 1'b1;
        @(negedge clk);
        n_cmp++; if (grant !== 2'd3) begin n_err++; $display("FAIL tmo_grant: got %0d want 3", grant); end
`ifdef BUS_TIMEOUT_EN
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (cpu_ack === 1'b1) seen = 1'b1;
        end
        cpu_as = 1'b0;
        n_cmp++; if (n != int'(TIMEOUT_CYCLES) + 1) begin n_err++; $display("FAIL tmo_cycles: got %0d want %0d", n, TIMEOUT_CYCLES + 1); end
        n_cmp++; if (dout !== 16'hFFFF) begin n_err++; $display("FAIL tmo_dout: got %h want ffff", dout); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_err_set: got %b want 1", timeout_err); end
        repeat (3) @(negedge clk);
        a_address = 22'h000777; a_as = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        mem_ack = 1'b1; mem_din = 16'h5A5A;
        @(negedge clk);
        mem_ack = 1'b0; a_as = 1'b0;
        n_cmp++; if (a_ack !== 1'b1 || dout !== 16'h5A5A) begin n_err++; $display("FAIL tmo_after_access: got ack %b dout %h want 1/5a5a", a_ack, dout); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky: got %b want 1", timeout_err); end
        do_reset();
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_err_reset: got %b want 0", timeout_err); end
`else
        n = 0; seen = 1'b0; acc = 3'b000;
        for (int i = 0; i < 100; i++) begin
            acc |= {a_ack, b_ack, cpu_ack};
            if (mem_as !== 1'b1 || timeout_err !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (acc !== 3'b000) begin n_err++; $display("FAIL notmo_acks: got %b want 000", acc); end
        n_cmp++; if (seen) begin n_err++; $display("FAIL notmo_hold: got mem_as/timeout_err change want steady 1/0"); end
        mem_ack = 1'b1; mem_din = 16'h0BAD;
        @(negedge clk);
        mem_ack = 1'b0; cpu_as = 1'b0;
        n_cmp++; if (cpu_ack !== 1'b1 || dout !== 16'h0BAD) begin n_err++; $display("FAIL notmo_late_ack: got ack %b dout %h want 1/0bad", cpu_ack, dout); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL notmo_err: got %b want 0", timeout_err); end
        repeat (2) @(negedge clk);
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        a_as = 1'b0; b_as = 1'b0; cpu_as = 1'b0; mem_ack = 1'b0;
        a_address = '0; b_address = '0; cpu_address = '0; mem_din = '0;
        test_reset();
        test_single_a();
        test_alternate();
        test_cpu_starvation();
        test_cpu_drop();
        test_reset_mid_busy();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
